// File: rtl/paralelo_serial_8b_if.sv
// Parallel word lane feeding the serializer and its serial-side outputs.
//   data_in/valid_in : parallel word and qualifier from the mux stage
//   data_out         : serial bit, MSB first
//   load             : high in the cycle whose closing edge samples data_in
//   active           : sync preamble finished
// master = upstream/driver side, slave = serializer side.
interface paralelo_serial_8b_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       load;
  logic       active;

  modport master (output data_in, valid_in, input data_out, load, active);
  modport slave  (input data_in, valid_in, output data_out, load, active);
endinterface

// File: rtl/paralelo_serial_8b.sv
// Parallel-to-serial transmit stage of the PHY lane.
// Shifts each 8-bit word out MSB-first at clk_32f, one word per 8 clocks.
// After reset a preamble of SYNC_WORDS comma bytes is sent before any data is
// accepted; whenever no valid word is present at a word boundary the comma is
// sent as the idle pattern.
// Ports:
//   clk_32f : bit clock, posedge
//   reset   : asynchronous, active-low
//   bus     : slave side of paralelo_serial_8b_if (data_in, valid_in in;
//             data_out, load, active out)
module paralelo_serial_8b #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_WORDS = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  paralelo_serial_8b_if.slave   bus
);

  localparam int SW = $clog2(SYNC_WORDS) + 1;
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_WORDS - 1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg, shift_nxt;
  logic [SW-1:0] sync_cnt, sync_nxt;
  logic          boundary, accept;

  assign boundary     = (bit_cnt == 3'd7);
  assign bus.data_out = shift_reg[7];
  assign bus.load     = boundary;
  assign bus.active   = (state == ACTIVE);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      bit_cnt   <= 3'd0;
      shift_reg <= COMMA;     // counts as the first preamble comma
      sync_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt + 3'd1;
      shift_reg <= shift_nxt;
      sync_cnt  <= sync_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_cnt;
    shift_nxt = {shift_reg[6:0], 1'b0};
    // The last preamble boundary already accepts data, so data follows the
    // final comma with no extra idle word.
    accept    = (state == ACTIVE) || (sync_cnt == SYNC_LAST);
    if (boundary) begin
      shift_nxt = (accept && bus.valid_in) ? bus.data_in : COMMA;
      if (state == SYNC) begin
        sync_nxt = sync_cnt + SW'(1);
        if (sync_cnt == SYNC_LAST) state_nxt = ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_8b.sv
module tb_paralelo_serial_8b;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  paralelo_serial_8b_if ifa ();
  paralelo_serial_8b_if ifb ();

  paralelo_serial_8b #(.COMMA(8'hBC), .SYNC_WORDS(4)) dut_a (
    .clk_32f(clk), .reset(rst_a), .bus(ifa.slave));
  paralelo_serial_8b #(.COMMA(8'hBC), .SYNC_WORDS(1)) dut_b (
    .clk_32f(clk), .reset(rst_b), .bus(ifb.slave));

  // Collects the word currently on the line; called at a negedge where the
  // word's MSB is showing, returns at the negedge showing the next MSB.
  task automatic get_byte(input bit sel, output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[7-i] = sel ? ifb.data_out : ifa.data_out;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    total++; if (ifa.data_out !== 1'b1) begin bad++; $display("FAIL rst_dout_a got=%b exp=1", ifa.data_out); end
    total++; if (ifa.load !== 1'b0) begin bad++; $display("FAIL rst_load_a got=%b exp=0", ifa.load); end
    total++; if (ifa.active !== 1'b0) begin bad++; $display("FAIL rst_active_a got=%b exp=0", ifa.active); end
    total++; if (ifb.data_out !== 1'b1) begin bad++; $display("FAIL rst_dout_b got=%b exp=1", ifb.data_out); end
    total++; if (ifb.active !== 1'b0) begin bad++; $display("FAIL rst_active_b got=%b exp=0", ifb.active); end
    repeat (2) @(negedge clk);
  endtask

  // Preamble: 55 is offered throughout, then 00 just before the accept boundary.
  task automatic test_sync_preamble();
    logic [7:0] b;
    ifa.data_in = 8'h55; ifa.valid_in = 1'b1;
    rst_a = 1'b1;  // at a negedge
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) begin
        if (w == 3 && i == 4) ifa.data_in = 8'h00;
        b[7-i] = ifa.data_out;
        total++; if (ifa.load !== (i == 7)) begin bad++; $display("FAIL sync_load w=%0d i=%0d got=%b exp=%b", w, i, ifa.load, (i == 7)); end
        total++; if (ifa.active !== 1'b0) begin bad++; $display("FAIL sync_active w=%0d i=%0d got=%b exp=0", w, i, ifa.active); end
        @(negedge clk);
      end
      total++; if (b !== 8'hBC) begin bad++; $display("FAIL sync_word%0d got=%h exp=bc", w, b); end
    end
    total++; if (ifa.active !== 1'b1) begin bad++; $display("FAIL active_rise got=%b exp=1", ifa.active); end
    ifa.data_in = 8'hA5;
    get_byte(1'b0, b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL first_data got=%h exp=00", b); end
  endtask

  task automatic test_data();
    logic [7:0] b;
    ifa.data_in = 8'hFF;
    get_byte(1'b0, b);
    total++; if (b !== 8'hA5) begin bad++; $display("FAIL data_a5 got=%h exp=a5", b); end
    ifa.data_in = 8'h00;
    get_byte(1'b0, b);
    total++; if (b !== 8'hFF) begin bad++; $display("FAIL data_ff got=%h exp=ff", b); end
    ifa.data_in = 8'h3C; ifa.valid_in = 1'b0;
    get_byte(1'b0, b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL data_00 got=%h exp=00", b); end
  endtask

  task automatic test_idle();
    logic [7:0] b;
    get_byte(1'b0, b);
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL idle_3c got=%h exp=bc", b); end
    // valid_in pulses mid-word only; both boundaries see valid_in=0
    for (int i = 0; i < 8; i++) begin
      ifa.valid_in = (i == 2 || i == 4);
      b[7-i] = ifa.data_out;
      @(negedge clk);
    end
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL idle_toggle1 got=%h exp=bc", b); end
    ifa.data_in = 8'hC3; ifa.valid_in = 1'b1;
    get_byte(1'b0, b);
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL idle_toggle2 got=%h exp=bc", b); end
    ifa.valid_in = 1'b0;
    get_byte(1'b0, b);
    total++; if (b !== 8'hC3) begin bad++; $display("FAIL idle_resume got=%h exp=c3", b); end
  endtask

  task automatic test_midword_reset();
    logic [7:0] b;
    ifa.data_in = 8'hA5; ifa.valid_in = 1'b1;
    get_byte(1'b0, b);
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL pre_rst_idle got=%h exp=bc", b); end
    ifa.valid_in = 1'b0;
    repeat (3) @(negedge clk);  // A5 bit 4 (a 0) now on the line
    total++; if (ifa.data_out !== 1'b0) begin bad++; $display("FAIL pre_rst_bit got=%b exp=0", ifa.data_out); end
    #2 rst_a = 1'b0;
    #1;
    total++; if (ifa.data_out !== 1'b1) begin bad++; $display("FAIL mrst_dout got=%b exp=1", ifa.data_out); end
    total++; if (ifa.load !== 1'b0) begin bad++; $display("FAIL mrst_load got=%b exp=0", ifa.load); end
    total++; if (ifa.active !== 1'b0) begin bad++; $display("FAIL mrst_active got=%b exp=0", ifa.active); end
    repeat (2) @(negedge clk);
    ifa.data_in = 8'h99; ifa.valid_in = 1'b1;
    rst_a = 1'b1;
    for (int w = 0; w < 4; w++) begin
      total++; if (ifa.active !== 1'b0) begin bad++; $display("FAIL mrst_pre_active w=%0d got=%b exp=0", w, ifa.active); end
      get_byte(1'b0, b);
      total++; if (b !== 8'hBC) begin bad++; $display("FAIL mrst_pre_word%0d got=%h exp=bc", w, b); end
    end
    total++; if (ifa.active !== 1'b1) begin bad++; $display("FAIL mrst_active_rise got=%b exp=1", ifa.active); end
    get_byte(1'b0, b);
    total++; if (b !== 8'h99) begin bad++; $display("FAIL mrst_data got=%h exp=99", b); end
  endtask

  task automatic test_sync1();
    logic [7:0] b;
    ifb.data_in = 8'h5A; ifb.valid_in = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = ifb.data_out;
      total++; if (ifb.load !== (i == 7)) begin bad++; $display("FAIL s1_load i=%0d got=%b exp=%b", i, ifb.load, (i == 7)); end
      total++; if (ifb.active !== 1'b0) begin bad++; $display("FAIL s1_active_pre i=%0d got=%b exp=0", i, ifb.active); end
      @(negedge clk);
    end
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL s1_comma got=%h exp=bc", b); end
    total++; if (ifb.active !== 1'b1) begin bad++; $display("FAIL s1_active got=%b exp=1", ifb.active); end
    ifb.valid_in = 1'b0;
    get_byte(1'b1, b);
    total++; if (b !== 8'h5A) begin bad++; $display("FAIL s1_data got=%h exp=5a", b); end
    get_byte(1'b1, b);
    total++; if (b !== 8'hBC) begin bad++; $display("FAIL s1_idle got=%h exp=bc", b); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.data_in = 8'h00; ifa.valid_in = 1'b0;
    ifb.data_in = 8'h00; ifb.valid_in = 1'b0;
    test_reset();
    test_sync_preamble();
    test_data();
    test_idle();
    test_midword_reset();
    test_sync1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
